// File: rtl/hacd_axi4_sram_model_if.sv
// rtl/hacd_axi4_sram_model_if.sv - AXI4 write/read bus bundle for the HACD MC SRAM model
// Purpose: groups the AW, W, B, AR and R channel signals of one AXI4 port.
// Modports: slave (memory model side), master (requester side).
interface hacd_axi4_sram_model_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]            axi_awlen;
    logic [ID_WIDTH-1:0]   axi_awid;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [BYTES-1:0]      axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [1:0]            axi_bresp;
    logic [ID_WIDTH-1:0]   axi_bid;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]            axi_arlen;
    logic [ID_WIDTH-1:0]   axi_arid;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic [ID_WIDTH-1:0]   axi_rid;

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awlen, axi_awid,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arlen, axi_arid,
        input  axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid
    );

    modport master (
        output axi_awvalid, axi_awaddr, axi_awlen, axi_awid,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arlen, axi_arid,
        output axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid
    );
endinterface

// File: rtl/hacd_axi4_sram_model.sv
// rtl/hacd_axi4_sram_model.sv - AXI4 INCR-burst slave memory model with read latency
// Purpose: real storage behind an AXI4 slave; byte-strobed write bursts with B responses,
//          read bursts after RD_LATENCY idle cycles with full rready backpressure.
// Ports: clk_i (rising-edge clock), rst_i (synchronous active-high reset),
//        axi (slave modport carrying the AW/W/B/AR/R channels).
module hacd_axi4_sram_model #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int ID_WIDTH   = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    hacd_axi4_sram_model_if.slave   axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write channel ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [7:0]            aw_len_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [7:0]            w_cnt_q;
    logic                  w_err_q;
    logic                  aw_fire, w_fire;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range, w_last_beat;

    // Index is computed at full address width so a burst running past DEPTH is detected, not wrapped.
    assign w_idx       = (aw_addr_q >> OFF) + ADDR_WIDTH'(w_cnt_q);
    assign w_in_range  = w_idx < ADDR_WIDTH'(DEPTH);
    assign w_last_beat = (w_cnt_q == aw_len_q);

    always_comb begin
        w_state_d = w_state_q;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        if (!rst_i) begin
            case (w_state_q)
                W_IDLE: if (axi.axi_awvalid) begin
                    aw_fire   = 1'b1;
                    w_state_d = W_DATA;
                end
                W_DATA: if (axi.axi_wvalid) begin
                    w_fire = 1'b1;
                    // Burst length comes from awlen; wlast only affects the response.
                    if (w_last_beat) w_state_d = W_RESP;
                end
                W_RESP: if (axi.axi_bready) w_state_d = W_IDLE;
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_id_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_fire) begin
                aw_addr_q <= axi.axi_awaddr;
                aw_len_q  <= axi.axi_awlen;
                aw_id_q   <= axi.axi_awid;
                w_cnt_q   <= '0;
                w_err_q   <= 1'b0;
            end
            if (w_fire) begin
                w_cnt_q <= w_cnt_q + 8'd1;
                if (!w_in_range || (axi.axi_wlast != w_last_beat)) w_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fire && w_in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi.axi_wstrb[b]) mem_q[w_idx[IDXW-1:0]][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [3:0]            lat_q;
    logic [7:0]            r_beat_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic                  ar_fire, ld_en;
    logic [7:0]            ld_beat, ld_len;
    logic [ADDR_WIDTH-1:0] ld_base, ld_idx;
    logic [ID_WIDTH-1:0]   ld_id;
    logic                  ld_in_range;

    assign ld_idx      = (ld_base >> OFF) + ADDR_WIDTH'(ld_beat);
    assign ld_in_range = ld_idx < ADDR_WIDTH'(DEPTH);

    // ld_en marks the edge at which a beat enters the output register; with zero latency
    // the first beat is taken straight from the AR channel since nothing is latched yet.
    always_comb begin
        r_state_d = r_state_q;
        ar_fire   = 1'b0;
        ld_en     = 1'b0;
        ld_beat   = r_beat_q + 8'd1;
        ld_base   = ar_addr_q;
        ld_len    = ar_len_q;
        ld_id     = ar_id_q;
        if (!rst_i) begin
            case (r_state_q)
                R_IDLE: if (axi.axi_arvalid) begin
                    ar_fire = 1'b1;
                    if (RD_LATENCY == 0) begin
                        ld_en     = 1'b1;
                        ld_beat   = 8'd0;
                        ld_base   = axi.axi_araddr;
                        ld_len    = axi.axi_arlen;
                        ld_id     = axi.axi_arid;
                        r_state_d = R_DATA;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
                R_WAIT: if (lat_q == 4'd0) begin
                    ld_en     = 1'b1;
                    ld_beat   = 8'd0;
                    r_state_d = R_DATA;
                end
                R_DATA: if (axi.axi_rready) begin
                    if (rlast_q) r_state_d = R_IDLE;
                    else         ld_en     = 1'b1;
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_id_q   <= '0;
            lat_q     <= '0;
            r_beat_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                ar_addr_q <= axi.axi_araddr;
                ar_len_q  <= axi.axi_arlen;
                ar_id_q   <= axi.axi_arid;
                lat_q     <= 4'(RD_LATENCY - 1);
            end
            if (r_state_q == R_WAIT) lat_q <= lat_q - 4'd1;
            if (ld_en) begin
                // Storage is sampled before any same-edge write lands, so a colliding beat sees old data.
                r_beat_q <= ld_beat;
                rdata_q  <= ld_in_range ? mem_q[ld_idx[IDXW-1:0]] : '0;
                rresp_q  <= ld_in_range ? 2'b00 : 2'b10;
                rlast_q  <= (ld_beat == ld_len);
                rid_q    <= ld_id;
            end
        end
    end

    // ---------------- outputs, all forced low while in reset ----------------
    assign axi.axi_awready = !rst_i && (w_state_q == W_IDLE);
    assign axi.axi_wready  = !rst_i && (w_state_q == W_DATA);
    assign axi.axi_bvalid  = !rst_i && (w_state_q == W_RESP);
    assign axi.axi_bresp   = (!rst_i && (w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;
    assign axi.axi_bid     = rst_i ? '0 : aw_id_q;
    assign axi.axi_arready = !rst_i && (r_state_q == R_IDLE);
    assign axi.axi_rvalid  = !rst_i && (r_state_q == R_DATA);
    assign axi.axi_rdata   = rst_i ? '0 : rdata_q;
    assign axi.axi_rresp   = rst_i ? 2'b00 : rresp_q;
    assign axi.axi_rlast   = !rst_i && rlast_q;
    assign axi.axi_rid     = rst_i ? '0 : rid_q;
endmodule
